// File: rtl/spi_master_pkg.sv
// Shared types and helpers for the multimode SPI master.
package spi_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  localparam int CPOL_IDX = 1;
  localparam int CPHA_IDX = 0;

  // A requested length of 0, or anything beyond the supported maximum, means a full-width transfer.
  function automatic int unsigned clamp_nbits(input int unsigned nbits, input int unsigned max_nbits);
    return ((nbits == 0) || (nbits > max_nbits)) ? max_nbits : nbits;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period timer: one-cycle tick every div+1 aclk cycles while enabled, restarting from zero when disabled.
module spi_sclk_gen #(
  parameter int W = 8
) (
  input  logic         aclk,
  input  logic         arst,
  input  logic         en,
  input  logic [W-1:0] div,
  output logic         tick
);

  logic [W-1:0] cnt_q;

  assign tick = en && (cnt_q == div);

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      cnt_q <= '0;
    end else if (!en || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/spi_master_multimode.sv
// SPI master with runtime length, mode, bit order and clock divider; config latched on a trigger edge.
module spi_master_multimode
  import spi_master_pkg::*;
#(
  parameter int                MAX_NBITS   = 32,
  parameter int                NBW         = $clog2(MAX_NBITS + 1),
  parameter int                NCLKDIVBITS = 8,
  parameter int                NCSBITS     = 3,
  parameter logic [NCSBITS-1:0] CS_RESET   = '1
) (
  input  logic                   aclk,
  input  logic                   arst,
  input  logic [MAX_NBITS-1:0]   spi_din,
  input  logic [NBW-1:0]         spi_nbits,
  input  logic [NCLKDIVBITS-1:0] spi_clkdiv,
  input  logic [1:0]             spi_mode,
  input  logic                   spi_lsb_first,
  input  logic [NCSBITS-1:0]     spi_cs,
  input  logic [NCSBITS-1:0]     spi_cs_idle,
  input  logic                   spi_trigger,
  output logic [MAX_NBITS-1:0]   spi_dout,
  output logic                   spi_busy,
  output logic                   spi_done,
  output logic                   spi_overrun,
  output logic [31:0]            spi_event_count,
  output logic [NCSBITS-1:0]     cs,
  output logic                   sclk,
  output logic                   mosi,
  input  logic                   miso
);

  state_t                   state_q, state_d;
  logic                     trig_q, trig_edge, tick;
  logic [MAX_NBITS-1:0]     tx_sh, rx_sh, dout_q, tx_align, tx_nxt;
  logic [NBW-1:0]           n_q, n_in, sh_amt;
  logic [NCLKDIVBITS-1:0]   div_q;
  logic                     cpha_q, lsb_q;
  logic [NCSBITS-1:0]       cs_q, cs_idle_q;
  logic [NBW:0]             hp_q, hp_last;
  logic                     sclk_q, mosi_q, done_q, ovr_q;
  logic [31:0]              evt_q;
  logic                     leading, sample, present;

  assign trig_edge = spi_trigger & ~trig_q;
  assign n_in      = NBW'(clamp_nbits(32'(spi_nbits), MAX_NBITS));
  assign sh_amt    = NBW'(MAX_NBITS) - n_in;
  // MSB-first words are left-justified so the outgoing bit is always at the top.
  assign tx_align  = spi_lsb_first ? spi_din : (spi_din << sh_amt);
  assign tx_nxt    = lsb_q ? (tx_sh >> 1) : (tx_sh << 1);
  assign hp_last   = {n_q, 1'b0} - (NBW+1)'(1);
  assign leading   = ~hp_q[0];
  assign sample    = leading ^ cpha_q;
  assign present   = ~sample && !(!cpha_q && (hp_q == hp_last)) && !(cpha_q && (hp_q == '0));

  spi_sclk_gen #(.W(NCLKDIVBITS)) u_sclk_gen (
    .aclk (aclk),
    .arst (arst),
    .en   (state_q != ST_IDLE),
    .div  (div_q),
    .tick (tick)
  );

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (trig_edge) state_d = ST_SETUP;
      ST_SETUP: if (tick) state_d = ST_SHIFT;
      ST_SHIFT: if (tick && (hp_q == hp_last)) state_d = ST_HOLD;
      ST_HOLD:  if (tick) state_d = ST_GAP;
      ST_GAP:   if (tick) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      trig_q <= 1'b0;  done_q <= 1'b0;  ovr_q <= 1'b0;
      cs_q <= CS_RESET;  cs_idle_q <= CS_RESET;
      sclk_q <= 1'b0;  mosi_q <= 1'b0;
      tx_sh <= '0;  rx_sh <= '0;  dout_q <= '0;
      n_q <= '0;  div_q <= '0;  cpha_q <= 1'b0;  lsb_q <= 1'b0;
      hp_q <= '0;  evt_q <= '0;
    end else begin
      trig_q <= spi_trigger;
      done_q <= 1'b0;
      if (trig_edge && (state_q != ST_IDLE)) ovr_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          cs_q   <= spi_cs_idle;
          sclk_q <= spi_mode[CPOL_IDX];
          mosi_q <= 1'b0;
          if (trig_edge) begin
            ovr_q     <= 1'b0;
            n_q       <= n_in;
            div_q     <= spi_clkdiv;
            cpha_q    <= spi_mode[CPHA_IDX];
            lsb_q     <= spi_lsb_first;
            cs_q      <= spi_cs;
            cs_idle_q <= spi_cs_idle;
            tx_sh     <= tx_align;
            mosi_q    <= spi_lsb_first ? tx_align[0] : tx_align[MAX_NBITS-1];
            rx_sh     <= '0;
            hp_q      <= '0;
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            sclk_q <= ~sclk_q;
            hp_q   <= hp_q + (NBW+1)'(1);
            if (sample) rx_sh <= lsb_q ? {miso, rx_sh[MAX_NBITS-1:1]} : {rx_sh[MAX_NBITS-2:0], miso};
            if (present) begin
              tx_sh  <= tx_nxt;
              mosi_q <= lsb_q ? tx_nxt[0] : tx_nxt[MAX_NBITS-1];
            end
          end
        end
        ST_HOLD: if (tick) cs_q <= cs_idle_q;
        ST_GAP: begin
          if (tick) begin
            done_q <= 1'b1;
            evt_q  <= evt_q + 32'd1;
            // LSB-first samples enter at the top; slide them down to bit 0.
            dout_q <= lsb_q ? (rx_sh >> (NBW'(MAX_NBITS) - n_q)) : rx_sh;
          end
        end
        default: ;
      endcase
    end
  end

  assign spi_busy        = (state_q != ST_IDLE);
  assign spi_done        = done_q;
  assign spi_overrun     = ovr_q;
  assign spi_dout        = dout_q;
  assign spi_event_count = evt_q;
  assign cs              = cs_q;
  assign sclk            = sclk_q;
  assign mosi            = mosi_q;

endmodule

// File: tb/tb_spi_master_multimode.sv
// Directed bench for spi_master_multimode: timing, modes, bit order, overrun, reset and counter wrap.
module tb_spi_master_multimode;

  logic        aclk = 1'b0;
  logic        arst = 1'b1;
  logic [31:0] spi_din = '0;
  logic [5:0]  spi_nbits = '0;
  logic [7:0]  spi_clkdiv = '0;
  logic [1:0]  spi_mode = '0;
  logic        spi_lsb_first = 1'b0;
  logic [2:0]  spi_cs = 3'b101;
  logic [2:0]  spi_cs_idle = 3'b110;
  logic        spi_trigger = 1'b0;
  logic [31:0] spi_dout;
  logic        spi_busy, spi_done, spi_overrun;
  logic [31:0] spi_event_count;
  logic [2:0]  cs;
  logic        sclk, mosi, miso;
  logic        loop_en = 1'b1;
  logic        tie_val = 1'b0;

  assign miso = loop_en ? mosi : tie_val;

  spi_master_multimode dut (
    .aclk(aclk), .arst(arst), .spi_din(spi_din), .spi_nbits(spi_nbits),
    .spi_clkdiv(spi_clkdiv), .spi_mode(spi_mode), .spi_lsb_first(spi_lsb_first),
    .spi_cs(spi_cs), .spi_cs_idle(spi_cs_idle), .spi_trigger(spi_trigger),
    .spi_dout(spi_dout), .spi_busy(spi_busy), .spi_done(spi_done),
    .spi_overrun(spi_overrun), .spi_event_count(spi_event_count),
    .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // Leading-edge monitor: records mosi just after every sclk edge that leaves the idle level.
  logic        mon_clr = 1'b1;
  logic        mon_cpol = 1'b0;
  logic        sclk_prev = 1'b0;
  int          lead_cnt = 0;
  logic [63:0] lead_bits = '0;
  always @(negedge aclk) begin
    if (mon_clr) begin
      lead_cnt  = 0;
      lead_bits = '0;
    end else if ((sclk !== sclk_prev) && (sclk !== mon_cpol)) begin
      lead_cnt  = lead_cnt + 1;
      lead_bits = {lead_bits[62:0], mosi};
    end
    sclk_prev = sclk;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(output int t0);
    mon_clr = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    mon_clr = 1'b0;
    @(posedge aclk); #1 spi_trigger = 1'b1;
    t0 = cyc;
    @(posedge aclk); #1 spi_trigger = 1'b0;
  endtask

  task automatic wait_done(input int t0, input int limit, output int dt);
    dt = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge aclk);
      if (spi_done === 1'b1) begin
        dt = cyc - t0;
        break;
      end
    end
  endtask

  int t0, dt;

  initial begin
    // Reset values while arst is held
    repeat (2) @(negedge aclk);
    chk("rst_cs", cs, 3'b111);
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_busy", spi_busy, 1'b0);
    chk("rst_done", spi_done, 1'b0);
    chk("rst_ovr", spi_overrun, 1'b0);
    chk("rst_dout", spi_dout, 32'h0);
    chk("rst_evt", spi_event_count, 32'h0);
    @(posedge aclk); #1 arst = 1'b0;
    repeat (2) @(negedge aclk);
    chk("idle_cs", cs, 3'b110);

    // 1: mode 0, MSB-first, 8 bits, H=2, loopback
    spi_din = 32'hA5; spi_nbits = 6'd8; spi_clkdiv = 8'd1; spi_mode = 2'd0;
    spi_lsb_first = 1'b0; loop_en = 1'b1; mon_cpol = 1'b0;
    start(t0);
    chk("t1_setup_cs", cs, 3'b101);
    chk("t1_setup_busy", spi_busy, 1'b1);
    chk("t1_setup_mosi", mosi, 1'b1);
    wait_done(t0, 200, dt);
    chk("t1_done_cyc", dt, 39);
    chk("t1_dout", spi_dout, 32'h0000_00A5);
    chk("t1_evt", spi_event_count, 32'd1);
    chk("t1_busy_done", spi_busy, 1'b0);
    chk("t1_lead_cnt", lead_cnt, 8);
    chk("t1_mosi_bits", lead_bits[7:0], 8'hA5);
    @(negedge aclk);
    chk("t1_done_pulse", spi_done, 1'b0);

    // 2: mode 3, LSB-first, 12 bits, H=1, miso tied high
    spi_mode = 2'd3; spi_lsb_first = 1'b1; spi_nbits = 6'd12; spi_clkdiv = 8'd0;
    spi_din = 32'h123; loop_en = 1'b0; tie_val = 1'b1; mon_cpol = 1'b1;
    repeat (2) @(negedge aclk);
    chk("t2_sclk_idle", sclk, 1'b1);
    start(t0);
    wait_done(t0, 200, dt);
    chk("t2_done_cyc", dt, 28);
    chk("t2_dout", spi_dout, 32'h0000_0FFF);
    chk("t2_lead_cnt", lead_cnt, 12);
    chk("t2_first_mosi", lead_bits[11], 1'b1);
    chk("t2_mosi_bits", lead_bits[11:0], 12'hC48);
    chk("t2_evt", spi_event_count, 32'd2);

    // 3: nbits=0 clamps to 32, mode 1, MSB-first, H=1, loopback
    spi_mode = 2'd1; spi_lsb_first = 1'b0; spi_nbits = 6'd0; spi_clkdiv = 8'd0;
    spi_din = 32'hDEADBEEF; loop_en = 1'b1; mon_cpol = 1'b0;
    start(t0);
    wait_done(t0, 300, dt);
    chk("t3_done_cyc", dt, 68);
    chk("t3_dout", spi_dout, 32'hDEADBEEF);
    chk("t3_lead_cnt", lead_cnt, 32);
    chk("t3_mosi_bits", lead_bits[31:0], 32'hDEADBEEF);

    // 4: trigger edge during a transfer sets overrun, transfer unaffected
    spi_mode = 2'd0; spi_nbits = 6'd8; spi_clkdiv = 8'd1; spi_din = 32'h3C;
    start(t0);
    repeat (6) @(posedge aclk);
    #1 spi_din = 32'hFF; spi_nbits = 6'd4; spi_clkdiv = 8'd0; spi_trigger = 1'b1;
    @(posedge aclk); #1 spi_trigger = 1'b0;
    chk("t4_ovr_set", spi_overrun, 1'b1);
    chk("t4_busy_mid", spi_busy, 1'b1);
    wait_done(t0, 200, dt);
    chk("t4_done_cyc", dt, 39);
    chk("t4_dout", spi_dout, 32'h0000_003C);
    chk("t4_evt", spi_event_count, 32'd4);
    chk("t4_ovr_sticky", spi_overrun, 1'b1);
    spi_din = 32'h5A; spi_nbits = 6'd8; spi_clkdiv = 8'd1;
    start(t0);
    chk("t4_ovr_clr", spi_overrun, 1'b0);
    wait_done(t0, 200, dt);
    chk("t4b_dout", spi_dout, 32'h0000_005A);
    chk("t4b_evt", spi_event_count, 32'd5);

    // 5: asynchronous reset in the middle of SHIFT
    start(t0);
    repeat (10) @(posedge aclk);
    #2 arst = 1'b1;
    #1;
    chk("t5_cs_async", cs, 3'b111);
    chk("t5_sclk_async", sclk, 1'b0);
    chk("t5_busy_async", spi_busy, 1'b0);
    chk("t5_mosi_async", mosi, 1'b0);
    @(posedge aclk); #1 arst = 1'b0;
    repeat (2) @(negedge aclk);
    chk("t5_cs_idle", cs, 3'b110);
    chk("t5_dout", spi_dout, 32'h0);
    chk("t5_evt", spi_event_count, 32'h0);
    chk("t5_done", spi_done, 1'b0);

    // 6: counter wrap; also nbits beyond max clamps, mode 2, LSB-first
    force dut.evt_q = 32'hFFFF_FFFF;
    @(posedge aclk); #1 release dut.evt_q;
    @(negedge aclk);
    chk("t6_preload", spi_event_count, 32'hFFFF_FFFF);
    spi_mode = 2'd2; spi_lsb_first = 1'b1; spi_nbits = 6'd40; spi_clkdiv = 8'd0;
    spi_din = 32'h0F0F_1234; loop_en = 1'b1; mon_cpol = 1'b1;
    start(t0);
    wait_done(t0, 300, dt);
    chk("t6_done_cyc", dt, 68);
    chk("t6_dout", spi_dout, 32'h0F0F_1234);
    chk("t6_evt_wrap", spi_event_count, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
